axi_mem_slave: RTL and testbench

- AXI4 slave responder with a 64-bit data path that terminates one downstream port of the LSU address-decode interconnect. It serves the full AXI4 write and read channels from an internal byte-writable SRAM array.
- Read and write engines are independent, each with its own FSM, so one read burst and one write burst can be in flight at the same time.
- Sideband inputs (region/lock/cache/prot/qos) are not ported; leave those interconnect outputs unconnected.

---
 rtl/axi_mem_slave.sv | 231 +++++++++++++++++++++++
 tb/tb_axi_mem_slave.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by a byte-writable 64-bit SRAM array.
// Independent read and write engines allow one burst per direction in flight.
module axi_mem_slave #(
  parameter int          TAG_W     = 3,
  parameter int          MEM_DEPTH = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             axi_awvalid,
  output logic             axi_awready,
  input  logic [TAG_W-1:0] axi_awid,
  input  logic [31:0]      axi_awaddr,
  input  logic [7:0]       axi_awlen,
  input  logic [2:0]       axi_awsize,
  input  logic [1:0]       axi_awburst,
  input  logic             axi_wvalid,
  output logic             axi_wready,
  input  logic [63:0]      axi_wdata,
  input  logic [7:0]       axi_wstrb,
  input  logic             axi_wlast,
  output logic             axi_bvalid,
  input  logic             axi_bready,
  output logic [1:0]       axi_bresp,
  output logic [TAG_W-1:0] axi_bid,
  input  logic             axi_arvalid,
  output logic             axi_arready,
  input  logic [TAG_W-1:0] axi_arid,
  input  logic [31:0]      axi_araddr,
  input  logic [7:0]       axi_arlen,
  input  logic [2:0]       axi_arsize,
  input  logic [1:0]       axi_arburst,
  output logic             axi_rvalid,
  input  logic             axi_rready,
  output logic [63:0]      axi_rdata,
  output logic [1:0]       axi_rresp,
  output logic [TAG_W-1:0] axi_rid,
  output logic             axi_rlast
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  logic [63:0] mem [MEM_DEPTH];

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic incr);
    return incr ? addr + (32'd1 << size) : addr;
  endfunction

  // WRAP, reserved burst types and beats wider than the bus error the whole burst.
  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return burst[1] || size[2];
  endfunction

  // ---------------- write engine ----------------
  logic [1:0]       w_state;
  logic [TAG_W-1:0] w_id;
  logic [31:0]      w_addr;
  logic [7:0]       w_len, w_cnt;
  logic [2:0]       w_size;
  logic             w_incr, w_burst_err, w_err;
  logic [31:0]      w_word;
  logic             w_beat_err, w_fire, w_final, w_err_next, mem_we;

  assign w_word     = (w_addr - BASE_ADDR) >> 3;
  assign w_beat_err = w_burst_err || (w_addr < BASE_ADDR) || (w_word >= 32'(MEM_DEPTH));
  assign w_fire     = axi_wvalid && axi_wready;
  assign w_final    = (w_cnt == w_len);
  assign w_err_next = w_err || w_beat_err || (axi_wlast != w_final);
  assign mem_we     = rst_l && w_fire && !w_beat_err;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      w_state     <= W_IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bresp   <= 2'b00;
      axi_bid     <= '0;
      w_id        <= '0;
      w_addr      <= '0;
      w_len       <= '0;
      w_cnt       <= '0;
      w_size      <= '0;
      w_incr      <= 1'b0;
      w_burst_err <= 1'b0;
      w_err       <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (axi_awvalid && axi_awready) begin
            axi_awready <= 1'b0;
            axi_wready  <= 1'b1;
            w_id        <= axi_awid;
            w_addr      <= axi_awaddr;
            w_len       <= axi_awlen;
            w_size      <= axi_awsize;
            w_incr      <= (axi_awburst == 2'b01);
            w_burst_err <= burst_bad(axi_awburst, axi_awsize);
            w_cnt       <= '0;
            w_err       <= 1'b0;
            w_state     <= W_DATA;
          end else begin
            axi_awready <= 1'b1;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            w_err <= w_err_next;
            // The beat counter, not wlast, decides where the burst ends.
            if (w_final) begin
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bid    <= w_id;
              axi_bresp  <= w_err_next ? 2'b10 : 2'b00;
              w_state    <= W_RESP;
            end else begin
              w_cnt  <= w_cnt + 8'd1;
              w_addr <= next_addr(w_addr, w_size, w_incr);
            end
          end
        end
        W_RESP: begin
          if (axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_bresp   <= 2'b00;
            axi_bid     <= '0;
            axi_awready <= 1'b1;
            w_state     <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset; contents survive rst_l like a real SRAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 8; b++) begin
        if (axi_wstrb[b]) mem[w_word[IDX_W-1:0]][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read engine ----------------
  logic [0:0]       r_state;
  logic [31:0]      r_addr;
  logic [7:0]       r_len, r_cnt;
  logic [2:0]       r_size;
  logic             r_incr, r_burst_err;
  logic [31:0]      r_load_addr, r_load_word;
  logic             r_load_err;
  logic [63:0]      r_load_data;

  // In IDLE the beat being loaded is beat 0 of the incoming AR; otherwise the next beat.
  assign r_load_addr = (r_state == R_IDLE) ? axi_araddr : next_addr(r_addr, r_size, r_incr);
  assign r_load_word = (r_load_addr - BASE_ADDR) >> 3;
  assign r_load_err  = ((r_state == R_IDLE) ? burst_bad(axi_arburst, axi_arsize) : r_burst_err)
                       || (r_load_addr < BASE_ADDR) || (r_load_word >= 32'(MEM_DEPTH));
  assign r_load_data = r_load_err ? 64'd0 : mem[r_load_word[IDX_W-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      r_state     <= R_IDLE;
      axi_arready <= 1'b0;
      axi_rvalid  <= 1'b0;
      axi_rdata   <= '0;
      axi_rresp   <= 2'b00;
      axi_rid     <= '0;
      axi_rlast   <= 1'b0;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
      r_size      <= '0;
      r_incr      <= 1'b0;
      r_burst_err <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (axi_arvalid && axi_arready) begin
            axi_arready <= 1'b0;
            axi_rvalid  <= 1'b1;
            axi_rid     <= axi_arid;
            axi_rdata   <= r_load_data;
            axi_rresp   <= r_load_err ? 2'b10 : 2'b00;
            axi_rlast   <= (axi_arlen == 8'd0);
            r_addr      <= axi_araddr;
            r_len       <= axi_arlen;
            r_size      <= axi_arsize;
            r_incr      <= (axi_arburst == 2'b01);
            r_burst_err <= burst_bad(axi_arburst, axi_arsize);
            r_cnt       <= '0;
            r_state     <= R_DATA;
          end else begin
            axi_arready <= 1'b1;
          end
        end
        R_DATA: begin
          if (axi_rready) begin
            if (axi_rlast) begin
              axi_rvalid  <= 1'b0;
              axi_rlast   <= 1'b0;
              axi_rresp   <= 2'b00;
              axi_rid     <= '0;
              axi_rdata   <= '0;
              axi_arready <= 1'b1;
              r_state     <= R_IDLE;
            end else begin
              r_cnt     <= r_cnt + 8'd1;
              r_addr    <= r_load_addr;
              axi_rdata <= r_load_data;
              axi_rresp <= r_load_err ? 2'b10 : 2'b00;
              axi_rlast <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave: outputs are sampled 1ns
// after each rising edge, and inputs for the next edge are driven at that point.
module tb_axi_mem_slave;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        axi_awvalid, axi_awready;
  logic [2:0]  axi_awid;
  logic [31:0] axi_awaddr;
  logic [7:0]  axi_awlen;
  logic [2:0]  axi_awsize;
  logic [1:0]  axi_awburst;
  logic        axi_wvalid, axi_wready;
  logic [63:0] axi_wdata;
  logic [7:0]  axi_wstrb;
  logic        axi_wlast;
  logic        axi_bvalid, axi_bready;
  logic [1:0]  axi_bresp;
  logic [2:0]  axi_bid;
  logic        axi_arvalid, axi_arready;
  logic [2:0]  axi_arid;
  logic [31:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;
  logic        axi_rvalid, axi_rready;
  logic [63:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic [2:0]  axi_rid;
  logic        axi_rlast;

  int checks = 0;
  int errors = 0;

  axi_mem_slave #(.TAG_W(3), .MEM_DEPTH(1024), .BASE_ADDR(32'h2000_0000)) dut (
    .clk(clk), .rst_l(rst_l),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awid(axi_awid),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wdata(axi_wdata),
    .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp), .axi_bid(axi_bid),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst),
    .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rdata(axi_rdata),
    .axi_rresp(axi_rresp), .axi_rid(axi_rid), .axi_rlast(axi_rlast)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, 64'(axi_awready), 0);
    check({tag, "_wready"},  64'(axi_wready), 0);
    check({tag, "_bvalid"},  64'(axi_bvalid), 0);
    check({tag, "_bresp"},   64'(axi_bresp), 0);
    check({tag, "_bid"},     64'(axi_bid), 0);
    check({tag, "_arready"}, 64'(axi_arready), 0);
    check({tag, "_rvalid"},  64'(axi_rvalid), 0);
    check({tag, "_rdata"},   axi_rdata, 0);
    check({tag, "_rresp"},   64'(axi_rresp), 0);
    check({tag, "_rid"},     64'(axi_rid), 0);
    check({tag, "_rlast"},   64'(axi_rlast), 0);
  endtask

  task automatic aw_send(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi_awvalid = 1'b1; axi_awid = id; axi_awaddr = addr;
    axi_awlen = len; axi_awsize = size; axi_awburst = burst;
    while (!axi_awready && n < 20) begin tick; n++; end
    check("aw_ready_wait", 64'(n < 20), 1);
    tick;
    axi_awvalid = 1'b0;
  endtask

  task automatic ar_send(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    axi_arvalid = 1'b1; axi_arid = id; axi_araddr = addr;
    axi_arlen = len; axi_arsize = size; axi_arburst = burst;
    while (!axi_arready && n < 20) begin tick; n++; end
    check("ar_ready_wait", 64'(n < 20), 1);
    tick;
    axi_arvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    axi_wvalid = 1'b1; axi_wdata = data; axi_wstrb = strb; axi_wlast = last;
    while (!axi_wready && n < 20) begin tick; n++; end
    check("w_ready_wait", 64'(n < 20), 1);
    tick;
    axi_wvalid = 1'b0;
  endtask

  task automatic b_take(input string tag, input logic [1:0] resp, input logic [2:0] id);
    int n = 0;
    axi_bready = 1'b1;
    while (!axi_bvalid && n < 20) begin tick; n++; end
    check({tag, "_bvalid_wait"}, 64'(n < 20), 1);
    check({tag, "_bresp"}, 64'(axi_bresp), 64'(resp));
    check({tag, "_bid"}, 64'(axi_bid), 64'(id));
    tick;
    axi_bready = 1'b0;
  endtask

  task automatic r_beat(input string tag, input logic [63:0] data, input logic [1:0] resp,
                        input logic last, input logic [2:0] id);
    check({tag, "_rvalid"}, 64'(axi_rvalid), 1);
    check({tag, "_rdata"}, axi_rdata, data);
    check({tag, "_rresp"}, 64'(axi_rresp), 64'(resp));
    check({tag, "_rlast"}, 64'(axi_rlast), 64'(last));
    check({tag, "_rid"}, 64'(axi_rid), 64'(id));
  endtask

  // INCR burst of 8-byte beats: beat k carries base + k*step.
  task automatic write_incr(input logic [2:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [63:0] base, input logic [63:0] step,
                            input logic [7:0] strb);
    aw_send(id, addr, len, 3'd3, 2'b01);
    for (int k = 0; k <= int'(len); k++) w_beat(base + 64'(k) * step, strb, k == int'(len));
    b_take("wr", 2'b00, id);
  endtask

  initial begin
    rst_l = 1'b0;
    axi_awvalid = 0; axi_awid = 0; axi_awaddr = 0; axi_awlen = 0; axi_awsize = 0; axi_awburst = 0;
    axi_wvalid = 0; axi_wdata = 0; axi_wstrb = 0; axi_wlast = 0; axi_bready = 0;
    axi_arvalid = 0; axi_arid = 0; axi_araddr = 0; axi_arlen = 0; axi_arsize = 0; axi_arburst = 0;
    axi_rready = 0;

    // Reset state
    tick; tick;
    check_all_zero("rst");
    rst_l = 1'b1;
    tick;
    check("rst_awready", 64'(axi_awready), 1);
    check("rst_arready", 64'(axi_arready), 1);

    // Single write then read, with latency checks
    aw_send(3'd5, 32'h2000_0010, 8'd0, 3'd3, 2'b01);
    check("t1_wready", 64'(axi_wready), 1);
    check("t1_awready", 64'(axi_awready), 0);
    w_beat(64'h1122_3344_5566_7788, 8'hFF, 1'b1);
    check("t1_bvalid", 64'(axi_bvalid), 1);
    b_take("t1", 2'b00, 3'd5);
    check("t1_bvalid_drop", 64'(axi_bvalid), 0);
    ar_send(3'd5, 32'h2000_0010, 8'd0, 3'd3, 2'b01);
    r_beat("t1", 64'h1122_3344_5566_7788, 2'b00, 1'b1, 3'd5);
    axi_rready = 1'b1; tick; axi_rready = 1'b0;
    check("t1_rvalid_drop", 64'(axi_rvalid), 0);

    // Burst with byte strobes over a pre-filled region
    write_incr(3'd1, 32'h2000_0000, 8'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 8'hFF);
    write_incr(3'd2, 32'h2000_0000, 8'd3, 64'd0, 64'd1, 8'h0F);
    ar_send(3'd3, 32'h2000_0000, 8'd3, 3'd3, 2'b01);
    axi_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r_beat($sformatf("t2_b%0d", k), 64'hFFFF_FFFF_0000_0000 | 64'(k), 2'b00, k == 3, 3'd3);
      tick;
    end
    axi_rready = 1'b0;
    check("t2_rvalid_drop", 64'(axi_rvalid), 0);

    // Read backpressure: rready low for two cycles mid-burst
    ar_send(3'd6, 32'h2000_0000, 8'd3, 3'd3, 2'b01);
    axi_rready = 1'b1;
    r_beat("t3_b0", 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b0, 3'd6);
    tick;
    r_beat("t3_b1", 64'hFFFF_FFFF_0000_0001, 2'b00, 1'b0, 3'd6);
    axi_rready = 1'b0;
    tick;
    r_beat("t3_hold1", 64'hFFFF_FFFF_0000_0001, 2'b00, 1'b0, 3'd6);
    tick;
    r_beat("t3_hold2", 64'hFFFF_FFFF_0000_0001, 2'b00, 1'b0, 3'd6);
    axi_rready = 1'b1;
    tick;
    r_beat("t3_b2", 64'hFFFF_FFFF_0000_0002, 2'b00, 1'b0, 3'd6);
    tick;
    r_beat("t3_b3", 64'hFFFF_FFFF_0000_0003, 2'b00, 1'b1, 3'd6);
    tick;
    axi_rready = 1'b0;
    check("t3_rvalid_drop", 64'(axi_rvalid), 0);

    // Write-response backpressure: bready low for five cycles
    aw_send(3'd3, 32'h2000_0020, 8'd0, 3'd3, 2'b01);
    w_beat(64'hCAFE, 8'hFF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_bhold%0d_bvalid", i), 64'(axi_bvalid), 1);
      check($sformatf("t3_bhold%0d_bresp", i), 64'(axi_bresp), 0);
      check($sformatf("t3_bhold%0d_bid", i), 64'(axi_bid), 3);
      tick;
    end
    b_take("t3b", 2'b00, 3'd3);

    // Error: write below BASE_ADDR
    aw_send(3'd1, 32'h1FFF_FFF8, 8'd0, 3'd3, 2'b01);
    w_beat(64'h0BAD_0BAD_0BAD_0BAD, 8'hFF, 1'b1);
    b_take("t4a", 2'b10, 3'd1);
    ar_send(3'd1, 32'h2000_0000, 8'd0, 3'd3, 2'b01);
    r_beat("t4a_word0", 64'hFFFF_FFFF_0000_0000, 2'b00, 1'b1, 3'd1);
    axi_rready = 1'b1; tick; axi_rready = 1'b0;

    // Error: WRAP read burst returns zero data with SLVERR on every beat
    ar_send(3'd2, 32'h2000_0000, 8'd3, 3'd3, 2'b10);
    axi_rready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r_beat($sformatf("t4b_b%0d", k), 64'd0, 2'b10, k == 3, 3'd2);
      tick;
    end
    axi_rready = 1'b0;
    check("t4b_rvalid_drop", 64'(axi_rvalid), 0);

    // Error: early wlast on a 2-beat burst; burst still runs both beats
    aw_send(3'd3, 32'h2000_0040, 8'd1, 3'd3, 2'b01);
    w_beat(64'hAAAA, 8'hFF, 1'b1);
    check("t4c_no_early_b", 64'(axi_bvalid), 0);
    check("t4c_wready_beat1", 64'(axi_wready), 1);
    w_beat(64'hBBBB, 8'hFF, 1'b0);
    check("t4c_bvalid", 64'(axi_bvalid), 1);
    b_take("t4c", 2'b10, 3'd3);

    // Concurrency: prefill words 15..22, then a 2-beat write to words 16..17
    // launched on the same edge as an 8-beat read of words 15..22.
    write_incr(3'd0, 32'h2000_0078, 8'd7, 64'h5555_0000_0000_0000, 64'd1, 8'hFF);
    axi_awvalid = 1'b1; axi_awid = 3'd2; axi_awaddr = 32'h2000_0080;
    axi_awlen = 8'd1; axi_awsize = 3'd3; axi_awburst = 2'b01;
    axi_arvalid = 1'b1; axi_arid = 3'd4; axi_araddr = 32'h2000_0078;
    axi_arlen = 8'd7; axi_arsize = 3'd3; axi_arburst = 2'b01;
    check("t5_awready", 64'(axi_awready), 1);
    check("t5_arready", 64'(axi_arready), 1);
    tick;
    axi_awvalid = 1'b0; axi_arvalid = 1'b0;
    axi_wvalid = 1'b1; axi_wdata = 64'hDEAD_0000_0000_0000; axi_wstrb = 8'hFF; axi_wlast = 1'b0;
    axi_rready = 1'b1;
    check("t5_wready", 64'(axi_wready), 1);
    r_beat("t5_b0", 64'h5555_0000_0000_0000, 2'b00, 1'b0, 3'd4);
    tick;
    axi_wdata = 64'hDEAD_0000_0000_0001; axi_wlast = 1'b1;
    r_beat("t5_b1", 64'h5555_0000_0000_0001, 2'b00, 1'b0, 3'd4);
    tick;
    axi_wvalid = 1'b0;
    check("t5_bvalid", 64'(axi_bvalid), 1);
    check("t5_bresp", 64'(axi_bresp), 0);
    check("t5_bid", 64'(axi_bid), 2);
    r_beat("t5_b2", 64'h5555_0000_0000_0002, 2'b00, 1'b0, 3'd4);
    axi_bready = 1'b1;
    tick;
    axi_bready = 1'b0;
    check("t5_bvalid_drop", 64'(axi_bvalid), 0);
    r_beat("t5_b3", 64'h5555_0000_0000_0003, 2'b00, 1'b0, 3'd4);
    for (int k = 4; k < 8; k++) begin
      tick;
      r_beat($sformatf("t5_b%0d", k), 64'h5555_0000_0000_0000 + 64'(k), 2'b00, k == 7, 3'd4);
    end
    tick;
    axi_rready = 1'b0;
    check("t5_rvalid_drop", 64'(axi_rvalid), 0);
    ar_send(3'd7, 32'h2000_0080, 8'd1, 3'd3, 2'b01);
    axi_rready = 1'b1;
    r_beat("t5_new0", 64'hDEAD_0000_0000_0000, 2'b00, 1'b0, 3'd7);
    tick;
    r_beat("t5_new1", 64'hDEAD_0000_0000_0001, 2'b00, 1'b1, 3'd7);
    tick;
    axi_rready = 1'b0;

    // Reset mid-burst: abandon a 3-beat write after two beats
    aw_send(3'd1, 32'h2000_0100, 8'd2, 3'd3, 2'b01);
    w_beat(64'h77, 8'hFF, 1'b0);
    w_beat(64'h88, 8'hFF, 1'b0);
    rst_l = 1'b0;
    tick;
    check_all_zero("t6_rst");
    rst_l = 1'b1;
    tick;
    check("t6_awready", 64'(axi_awready), 1);
    check("t6_arready", 64'(axi_arready), 1);
    check("t6_no_bvalid", 64'(axi_bvalid), 0);
    write_incr(3'd7, 32'h2000_0110, 8'd0, 64'h99, 64'd0, 8'hFF);
    ar_send(3'd5, 32'h2000_0100, 8'd2, 3'd3, 2'b01);
    axi_rready = 1'b1;
    r_beat("t6_b0", 64'h77, 2'b00, 1'b0, 3'd5);
    tick;
    r_beat("t6_b1", 64'h88, 2'b00, 1'b0, 3'd5);
    tick;
    r_beat("t6_b2", 64'h99, 2'b00, 1'b1, 3'd5);
    tick;
    axi_rready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
